// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: job sequencer for one MAC block. A command sets the job
// configuration. The block then streams operand beats into the MAC, times the
// MAC result pipeline and returns results on a valid/ready channel.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   abort                    abort the current job (present only when
//                            MAC_SEQ_ABORT_EN is defined)
//   cmd_valid/cmd_ready      command handshake
//   cmd_mode/acc/init/len    job mode, accumulate flag, initial value and
//                            beat count
//   op_valid/op_ready        operand beat handshake; op_a is A3..A0, op_b is B0
//   res_valid/res_ready      result handshake; res_data holds the result and
//                            res_last marks the final result of a job
//   mac_rst, mac_en, mac_cfg drive the MAC block's rst, en and cfg
//                            (mac_cfg is {init, conf})
//   mac_a0..a3, mac_b0       MAC operand registers
//   mac_c                    MAC block output
//   busy                     high whenever the FSM is not idle
//
// The `MAC_*` width and mode macros fall back to local defaults when the MAC
// block's header has not already defined them.

`ifndef MAC_MIN_WIDTH
`define MAC_MIN_WIDTH 8
`endif
`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 32
`endif
`ifndef MAC_CONF_WIDTH
`define MAC_CONF_WIDTH 3
`endif
`ifndef MAC_SINGLE
`define MAC_SINGLE 2'd0
`endif
`ifndef MAC_DUAL
`define MAC_DUAL 2'd1
`endif
`ifndef MAC_QUAD
`define MAC_QUAD 2'd2
`endif

module mac_seq_ctrl #(
    parameter int LEN_WIDTH  = 8,
    parameter int RESULT_LAT = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
`ifdef MAC_SEQ_ABORT_EN
    input  logic                                     abort,
`endif
    input  logic                                     cmd_valid,
    output logic                                     cmd_ready,
    input  logic [1:0]                               cmd_mode,
    input  logic                                     cmd_acc,
    input  logic [`MAC_ACC_WIDTH-1:0]                cmd_init,
    input  logic [LEN_WIDTH-1:0]                     cmd_len,
    input  logic                                     op_valid,
    output logic                                     op_ready,
    input  logic [4*`MAC_MIN_WIDTH-1:0]              op_a,
    input  logic [`MAC_MIN_WIDTH-1:0]                op_b,
    output logic                                     res_valid,
    input  logic                                     res_ready,
    output logic [`MAC_ACC_WIDTH-1:0]                res_data,
    output logic                                     res_last,
    output logic                                     mac_rst,
    output logic                                     mac_en,
    output logic [`MAC_ACC_WIDTH+`MAC_CONF_WIDTH-1:0] mac_cfg,
    output logic [`MAC_MIN_WIDTH-1:0]                mac_a0,
    output logic [`MAC_MIN_WIDTH-1:0]                mac_a1,
    output logic [`MAC_MIN_WIDTH-1:0]                mac_a2,
    output logic [`MAC_MIN_WIDTH-1:0]                mac_a3,
    output logic [`MAC_MIN_WIDTH-1:0]                mac_b0,
    input  logic [`MAC_ACC_WIDTH-1:0]                mac_c,
    output logic                                     busy
);

    localparam int MW = `MAC_MIN_WIDTH;
    localparam int AW = `MAC_ACC_WIDTH;
    localparam int CW = `MAC_CONF_WIDTH;

    // The drain counter starts at RESULT_LAT-1 and reaches 0 in the cycle
    // where mac_c is valid.
    localparam logic [1:0] LAT_INIT = 2'(RESULT_LAT - 1);

    localparam logic [LEN_WIDTH-1:0] CNT_ONE = LEN_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q;
    logic [1:0]           lat_q;
    logic                 abort_hit;
    logic                 cmd_fire;
    logic                 beat_fire;
    logic                 capture;
    logic                 consume;
    logic [1:0]           mode_n;
    logic [CW-1:0]        conf_d;
    logic                 job_acc;
    logic [AW-1:0]        job_init;

`ifdef MAC_SEQ_ABORT_EN
    assign abort_hit = abort && (state_q != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign job_acc  = mac_cfg[CW-1];
    assign job_init = mac_cfg[AW+CW-1:CW];

    // Any mode code other than DUAL or QUAD is stored as SINGLE.
    always_comb begin
        mode_n = `MAC_SINGLE;
        if (cmd_mode == `MAC_DUAL || cmd_mode == `MAC_QUAD)
            mode_n = cmd_mode;
        conf_d        = '0;
        conf_d[1:0]   = mode_n;
        conf_d[CW-1]  = cmd_acc;
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        cmd_fire  = 1'b0;
        beat_fire = 1'b0;
        capture   = 1'b0;
        consume   = 1'b0;
        mac_rst   = rst || (state_q == S_LOAD) || abort_hit;
        busy      = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = !rst;
                cmd_fire  = cmd_valid && !rst;
                if (cmd_fire)
                    state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = (cnt_q != '0) ? S_RUN : S_HOLD;
            end
            S_RUN: begin
                // RUN never coexists with an in-flight beat or held result,
                // so beats remaining is the only condition in both modes.
                op_ready  = (cnt_q != '0) && !abort_hit;
                beat_fire = op_valid && op_ready;
                if (beat_fire && (!job_acc || cnt_q == CNT_ONE))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (lat_q == '0) begin
                    capture = !abort_hit;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                res_valid = !abort_hit;
                consume   = res_valid && res_ready;
                if (consume)
                    state_d = res_last ? S_IDLE : S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_hit)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            lat_q    <= '0;
            mac_en   <= 1'b0;
            mac_cfg  <= '0;
            mac_a0   <= '0;
            mac_a1   <= '0;
            mac_a2   <= '0;
            mac_a3   <= '0;
            mac_b0   <= '0;
            res_data <= '0;
            res_last <= 1'b0;
        end else begin
            state_q <= state_d;
            mac_en  <= beat_fire;

            if (cmd_fire) begin
                mac_cfg <= {cmd_init, conf_d};
                cnt_q   <= cmd_len;
            end

            if (beat_fire) begin
                mac_a0 <= op_a[0*MW +: MW];
                mac_a1 <= op_a[1*MW +: MW];
                mac_a2 <= op_a[2*MW +: MW];
                mac_a3 <= op_a[3*MW +: MW];
                mac_b0 <= op_b;
                cnt_q  <= cnt_q - CNT_ONE;
                lat_q  <= LAT_INIT;
            end else if (state_q == S_DRAIN && lat_q != '0) begin
                lat_q <= lat_q - 2'd1;
            end

            // An empty job answers directly without sampling the MAC.
            if (state_q == S_LOAD && cnt_q == '0) begin
                res_data <= job_acc ? job_init : '0;
                res_last <= 1'b1;
            end

            if (capture) begin
                res_data <= mac_c;
                res_last <= (cnt_q == '0);
            end

            if (consume)
                res_last <= 1'b0;

            if (abort_hit) begin
                cnt_q    <= '0;
                res_last <= 1'b0;
            end
        end
    end

endmodule
